// File: rtl/vga_balayage.sv
// -----------------------------------------------------------------------------
// vga_balayage : VGA raster generator (640x480@60 by default)
//
// Produces the hpos/vpos position bus consumed by the object renderers, takes
// back their combined colour, and presents colour, visible flag, sync pulses
// and a frame-start pulse to the board pins. Every pin output is registered
// one pixel after the hpos/vpos it describes, so all outputs refer to the same
// pixel in the same cycle.
//
// Configuration macro:
//   VGA_PIX_DIV2_EN  defined   -> pixel step on every other clk (50 MHz clk,
//                                 25 MHz pixel rate); outputs hold between
//                                 steps.
//                    undefined -> every clk is a pixel step.
//
// Ports:
//   clk          in   1   system clock
//   rst_n        in   1   synchronous reset, active low
//   couleur_in   in   5   renderer colour for the current hpos/vpos
//   hpos         out  11  current column, 0..H_TOTAL-1
//   vpos         out  11  current line,   0..V_TOTAL-1
//   hsync        out  1   horizontal sync, one pixel behind hpos
//   vsync        out  1   vertical sync, one pixel behind hpos
//   visible      out  1   pixel on couleur_out is in the visible area
//   couleur_out  out  5   registered colour, 0 outside the visible area
//   debut_trame  out  1   one-pixel pulse qualifying pixel (0,0) on outputs
// -----------------------------------------------------------------------------
module vga_balayage #(
   parameter int unsigned H_VISIBLE  = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_VISIBLE  = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter logic        SYNC_ACTIF = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  couleur_in,
   output logic [10:0] hpos,
   output logic [10:0] vpos,
   output logic        hsync,
   output logic        vsync,
   output logic        visible,
   output logic [4:0]  couleur_out,
   output logic        debut_trame
);

   // Raster geometry, all reduced to 11-bit unsigned constants so every
   // comparison below is a plain 11-bit compare.
   localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS_END    = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS_END    = 11'(V_VISIBLE);
   localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FP);
   localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FP);
   localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

   // ---------------------------------------------------------------------------
   // Pixel enable
   // ---------------------------------------------------------------------------
   logic pix_en;

`ifdef VGA_PIX_DIV2_EN
   // Cleared by reset, so the first clk after release is idle and the second
   // one is the first pixel step.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pix_en <= 1'b0;
      end else begin
         pix_en <= ~pix_en;
      end
   end
`else
   assign pix_en = 1'b1;
`endif

   // ---------------------------------------------------------------------------
   // Position counters
   // ---------------------------------------------------------------------------
   logic h_fin;
   logic v_fin;

   assign h_fin = (hpos == H_LAST);
   assign v_fin = (vpos == V_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hpos <= '0;
         vpos <= '0;
      end else if (pix_en) begin
         if (h_fin) begin
            hpos <= '0;
            // vpos only moves at the end of a line, which keeps the vertical
            // sync edges aligned on hpos=0 boundaries.
            vpos <= v_fin ? 11'd0 : vpos + 11'd1;
         end else begin
            hpos <= hpos + 11'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 1: decode of the current position
   // ---------------------------------------------------------------------------
   logic vis_c;
   logic hs_c;
   logic vs_c;
   logic ds_c;

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch can be inferred.
   always_comb begin
      vis_c = 1'b0;
      hs_c  = 1'b0;
      vs_c  = 1'b0;
      ds_c  = 1'b0;

      if ((hpos < H_VIS_END) && (vpos < V_VIS_END)) begin
         vis_c = 1'b1;
      end
      if ((hpos >= H_SYNC_START) && (hpos < H_SYNC_END)) begin
         hs_c = 1'b1;
      end
      if ((vpos >= V_SYNC_START) && (vpos < V_SYNC_END)) begin
         vs_c = 1'b1;
      end
      if ((hpos == 11'd0) && (vpos == 11'd0)) begin
         ds_c = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 2: pin registers, one pixel behind hpos/vpos
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         couleur_out <= '0;
         visible     <= 1'b0;
         hsync       <= ~SYNC_ACTIF;
         vsync       <= ~SYNC_ACTIF;
         debut_trame <= 1'b0;
      end else if (pix_en) begin
         // Renderer colour is only trusted inside the visible area; anything
         // it drives during blanking is dropped here.
         couleur_out <= vis_c ? couleur_in : 5'd0;
         visible     <= vis_c;
         hsync       <= hs_c ? SYNC_ACTIF : ~SYNC_ACTIF;
         vsync       <= vs_c ? SYNC_ACTIF : ~SYNC_ACTIF;
         debut_trame <= ds_c;
      end
   end

endmodule

// File: tb/tb_vga_balayage.sv
// -----------------------------------------------------------------------------
// tb_vga_balayage : self-checking bench for vga_balayage with reduced raster
// parameters (H 8/2/2/2, V 4/1/1/1, active-low sync; 14 x 7 total).
// -----------------------------------------------------------------------------
module tb_vga_balayage;

   localparam int HV = 8;
   localparam int HF = 2;
   localparam int HS = 2;
   localparam int HB = 2;
   localparam int VV = 4;
   localparam int VF = 1;
   localparam int VS = 1;
   localparam int VB = 1;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;

   logic        clk;
   logic        rst_n;
   logic [4:0]  couleur_in;
   logic [10:0] hpos;
   logic [10:0] vpos;
   logic        hsync;
   logic        vsync;
   logic        visible;
   logic [4:0]  couleur_out;
   logic        debut_trame;

   vga_balayage #(
      .H_VISIBLE (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_VISIBLE (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .SYNC_ACTIF(1'b0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .couleur_in (couleur_in),
      .hpos       (hpos),
      .vpos       (vpos),
      .hsync      (hsync),
      .vsync      (vsync),
      .visible    (visible),
      .couleur_out(couleur_out),
      .debut_trame(debut_trame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: a linear pixel index over the whole frame; position is
   // derived by division, outputs are the rules applied to the previous pixel.
   // ---------------------------------------------------------------------------
   int       m_pix = 0;
   bit       m_pe  = 1'b0;
   bit       m_vis = 1'b0;
   bit [4:0] m_col = '0;
   bit       m_hs  = 1'b1;
   bit       m_vs  = 1'b1;
   bit       m_ds  = 1'b0;

   task automatic model_pixel();
      int h;
      int v;
      h     = m_pix % HT;
      v     = m_pix / HT;
      m_vis = (h < HV) && (v < VV);
      m_col = m_vis ? couleur_in : 5'd0;
      m_hs  = !((h >= HV + HF) && (h < HV + HF + HS));
      m_vs  = !((v >= VV + VF) && (v < VV + VF + VS));
      m_ds  = (m_pix == 0);
      m_pix = (m_pix + 1) % (HT * VT);
   endtask

   task automatic model_step();
      if (!rst_n) begin
         m_pix = 0;
         m_pe  = 1'b0;
         m_vis = 1'b0;
         m_col = '0;
         m_hs  = 1'b1;
         m_vs  = 1'b1;
         m_ds  = 1'b0;
      end else begin
`ifdef VGA_PIX_DIV2_EN
         if (m_pe) model_pixel();
         m_pe = !m_pe;
`else
         model_pixel();
`endif
      end
   endtask

   // Inputs are changed at the falling edge; the model follows each rising edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic compare_model(input string tag);
      check({tag, ".hpos"},    hpos,        m_pix % HT);
      check({tag, ".vpos"},    vpos,        m_pix / HT);
      check({tag, ".hsync"},   hsync,       m_hs);
      check({tag, ".vsync"},   vsync,       m_vs);
      check({tag, ".visible"}, visible,     m_vis);
      check({tag, ".couleur"}, couleur_out, m_col);
      check({tag, ".debut"},   debut_trame, m_ds);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".hpos"},    hpos,        0);
      check({tag, ".vpos"},    vpos,        0);
      check({tag, ".hsync"},   hsync,       1);
      check({tag, ".vsync"},   vsync,       1);
      check({tag, ".visible"}, visible,     0);
      check({tag, ".couleur"}, couleur_out, 0);
      check({tag, ".debut"},   debut_trame, 0);
   endtask

   typedef struct {
      logic        rst_n;
      logic [4:0]  cin;
      logic [10:0] h;
      logic [10:0] v;
      logic        hs;
      logic        vs;
      logic        vis;
      logic [4:0]  col;
      logic        ds;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs [NVEC];

   initial begin
      int  ds_edges [3];
      int  n_edges;
      int  cyc;
      bit  found;
      bit  prev_ds;

      rst_n      = 1'b0;
      couleur_in = 5'd20;

      // Table: reset for 3 clk, then the first line and the wrap into line 1.
      // Each row: inputs before the edge, outputs expected after it.
      vecs[0]  = '{1'b0, 5'd20, 11'd0,  11'd0, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0};
      vecs[1]  = '{1'b0, 5'd20, 11'd0,  11'd0, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0};
      vecs[2]  = '{1'b0, 5'd20, 11'd0,  11'd0, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0};
      vecs[3]  = '{1'b1, 5'd20, 11'd1,  11'd0, 1'b1, 1'b1, 1'b1, 5'd20, 1'b1};
      vecs[4]  = '{1'b1, 5'd20, 11'd2,  11'd0, 1'b1, 1'b1, 1'b1, 5'd20, 1'b0};
      vecs[5]  = '{1'b1, 5'd20, 11'd3,  11'd0, 1'b1, 1'b1, 1'b1, 5'd20, 1'b0};
      vecs[6]  = '{1'b1, 5'd20, 11'd4,  11'd0, 1'b1, 1'b1, 1'b1, 5'd20, 1'b0};
      vecs[7]  = '{1'b1, 5'd20, 11'd5,  11'd0, 1'b1, 1'b1, 1'b1, 5'd20, 1'b0};
      vecs[8]  = '{1'b1, 5'd20, 11'd6,  11'd0, 1'b1, 1'b1, 1'b1, 5'd20, 1'b0};
      vecs[9]  = '{1'b1, 5'd20, 11'd7,  11'd0, 1'b1, 1'b1, 1'b1, 5'd20, 1'b0};
      vecs[10] = '{1'b1, 5'd9,  11'd8,  11'd0, 1'b1, 1'b1, 1'b1, 5'd9,  1'b0};
      vecs[11] = '{1'b1, 5'd7,  11'd9,  11'd0, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0};
      vecs[12] = '{1'b1, 5'd20, 11'd10, 11'd0, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0};
      vecs[13] = '{1'b1, 5'd20, 11'd11, 11'd0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0};
      vecs[14] = '{1'b1, 5'd20, 11'd12, 11'd0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0};
      vecs[15] = '{1'b1, 5'd20, 11'd13, 11'd0, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0};
      vecs[16] = '{1'b1, 5'd20, 11'd0,  11'd1, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0};
      vecs[17] = '{1'b1, 5'd20, 11'd1,  11'd1, 1'b1, 1'b1, 1'b1, 5'd20, 1'b0};

      @(negedge clk);

`ifndef VGA_PIX_DIV2_EN
      for (int i = 0; i < NVEC; i++) begin
         rst_n      = vecs[i].rst_n;
         couleur_in = vecs[i].cin;
         tick();
         check($sformatf("vec%0d.hpos", i),    hpos,        vecs[i].h);
         check($sformatf("vec%0d.vpos", i),    vpos,        vecs[i].v);
         check($sformatf("vec%0d.hsync", i),   hsync,       vecs[i].hs);
         check($sformatf("vec%0d.vsync", i),   vsync,       vecs[i].vs);
         check($sformatf("vec%0d.visible", i), visible,     vecs[i].vis);
         check($sformatf("vec%0d.couleur", i), couleur_out, vecs[i].col);
         check($sformatf("vec%0d.debut", i),   debut_trame, vecs[i].ds);
      end
`else
      // Halved pixel rate: reset values, then hpos 0,1,1,2,2,3 per clk.
      for (int i = 0; i < 3; i++) begin
         tick();
         check_reset_values($sformatf("div2_rst%0d", i));
      end
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("div2_step%0d.hpos", i), hpos, (i + 1) / 2);
         compare_model($sformatf("div2_step%0d", i));
      end
`endif

      // Frame wrap: from (13,6) the next pixel step lands on (0,0).
      rst_n      = 1'b1;
      couleur_in = 5'd20;
      found      = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
         if (hpos == 11'(HT - 1) && vpos == 11'(VT - 1)) found = 1'b1;
         else tick();
      end
      check("wait_last_pixel", found, 1);
      found = 1'b0;
      for (int i = 0; i < 3 && !found; i++) begin
         tick();
         if (hpos != 11'(HT - 1)) found = 1'b1;
      end
      check("wrap.hpos", hpos, 0);
      check("wrap.vpos", vpos, 0);
`ifdef VGA_PIX_DIV2_EN
      tick();
`endif
      tick();
      check("wrap.debut", debut_trame, 1);

      // Frame-start pulse period: rising edges every HT*VT pixel steps.
      n_edges = 0;
      cyc     = 0;
      prev_ds = debut_trame;
      for (int i = 0; i < 1000 && n_edges < 3; i++) begin
         tick();
         cyc++;
         if (debut_trame && !prev_ds) begin
            ds_edges[n_edges] = cyc;
            n_edges++;
         end
         prev_ds = debut_trame;
      end
      check("wait_debut_edges", n_edges, 3);
      if (n_edges == 3) begin
`ifdef VGA_PIX_DIV2_EN
         check("debut_period0", ds_edges[1] - ds_edges[0], 2 * HT * VT);
         check("debut_period1", ds_edges[2] - ds_edges[1], 2 * HT * VT);
`else
         check("debut_period0", ds_edges[1] - ds_edges[0], HT * VT);
         check("debut_period1", ds_edges[2] - ds_edges[1], HT * VT);
`endif
      end

      // Mid-frame reset at (9,2).
      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
         if (hpos == 11'd9 && vpos == 11'd2) found = 1'b1;
         else tick();
      end
      check("wait_9_2", found, 1);
      rst_n = 1'b0;
      tick();
      check_reset_values("midrst");
      rst_n = 1'b1;
      tick();
`ifdef VGA_PIX_DIV2_EN
      check("midrst_resume.hpos", hpos, 0);
`else
      check("midrst_resume.hpos", hpos, 1);
`endif
      check("midrst_resume.vpos", vpos, 0);

      // Randomised colour and occasional resets against the model.
      for (int i = 0; i < 600; i++) begin
         rst_n      = ($urandom_range(0, 49) != 0);
         couleur_in = 5'($urandom);
         tick();
         compare_model($sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
